// File: rtl/mac_sequencer.sv
// Layer sequencer: walks NUM_NEURONS weight rows through an external MAC,
// applies optional ReLU and collects the per-neuron results.
module mac_sequencer #(
  parameter int unsigned NUM_FEATURES   = 4,
  parameter int unsigned NUM_NEURONS    = 4,
  parameter int unsigned FP_TOTAL_BITS  = 16,
  parameter int unsigned FP_FRAC_BITS   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         layer_start,
  input  logic                                         relu_en,
  input  logic [NUM_FEATURES-1:0][FP_TOTAL_BITS-1:0]   x_in,
  output logic [AW-1:0]                                w_addr,
  input  logic [NUM_FEATURES-1:0][FP_TOTAL_BITS-1:0]   w_row,
  input  logic [FP_TOTAL_BITS-1:0]                     b_row,
  output logic                                         mac_start,
  output logic [NUM_FEATURES-1:0][FP_TOTAL_BITS-1:0]   mac_x,
  output logic [NUM_FEATURES-1:0][FP_TOTAL_BITS-1:0]   mac_w,
  output logic [FP_TOTAL_BITS-1:0]                     mac_bias,
  input  logic [FP_TOTAL_BITS-1:0]                     mac_y,
  input  logic                                         mac_done,
  output logic [NUM_NEURONS-1:0][FP_TOTAL_BITS-1:0]    y_out,
  output logic                                         busy,
  output logic                                         layer_done,
  output logic                                         err
);

  localparam int unsigned W  = FP_TOTAL_BITS;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  if (NUM_NEURONS < 1 || FP_FRAC_BITS >= FP_TOTAL_BITS) begin : g_param_check
    $error("mac_sequencer: invalid parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_WAIT, S_STORE, S_DONE
  } state_t;

  state_t                              r_state;
  logic [AW-1:0]                       r_idx;
  logic [AW-1:0]                       r_w_addr;
  logic [CW-1:0]                       r_cnt;
  logic                                r_relu;
  logic [W-1:0]                        r_y;
  logic                                r_mac_start;
  logic [NUM_FEATURES-1:0][W-1:0]      r_mac_x;
  logic [NUM_FEATURES-1:0][W-1:0]      r_mac_w;
  logic [W-1:0]                        r_mac_bias;
  logic [NUM_NEURONS-1:0][W-1:0]       r_y_out;
  logic                                r_busy;
  logic                                r_layer_done;
  logic                                r_err;

  // w_addr is set on FETCH entry so the synchronous row read lands in LOAD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_w_addr     <= '0;
      r_cnt        <= '0;
      r_relu       <= 1'b0;
      r_y          <= '0;
      r_mac_start  <= 1'b0;
      r_mac_x      <= '0;
      r_mac_w      <= '0;
      r_mac_bias   <= '0;
      r_y_out      <= '0;
      r_busy       <= 1'b0;
      r_layer_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_mac_start  <= 1'b0;
      r_layer_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (layer_start) begin
            r_mac_x  <= x_in;
            r_relu   <= relu_en;
            r_idx    <= '0;
            r_w_addr <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_mac_w     <= w_row;
          r_mac_bias  <= b_row;
          r_mac_start <= 1'b1;
          r_state     <= S_START;
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (mac_done) begin
            r_y     <= mac_y;
            r_state <= S_STORE;
          end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STORE: begin
          r_y_out[r_idx] <= (r_relu && r_y[W-1]) ? '0 : r_y;
          if (r_idx == AW'(NUM_NEURONS - 1)) begin
            r_state <= S_DONE;
          end else begin
            r_idx    <= r_idx + AW'(1);
            r_w_addr <= r_idx + AW'(1);
            r_state  <= S_FETCH;
          end
        end
        S_DONE: begin
          r_layer_done <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_addr     = r_w_addr;
  assign mac_start  = r_mac_start;
  assign mac_x      = r_mac_x;
  assign mac_w      = r_mac_w;
  assign mac_bias   = r_mac_bias;
  assign y_out      = r_y_out;
  assign busy       = r_busy;
  assign layer_done = r_layer_done;
  assign err        = r_err;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: behavioural MAC and weight memory, random layers
// compared against a plain-arithmetic Q8.8 neuron reference.
module tb_mac_sequencer;
  localparam int unsigned NF = 4;
  localparam int unsigned NN = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned AW = 2;

  logic                   clk, reset, layer_start, relu_en;
  logic [NF-1:0][W-1:0]   x_in, w_row, mac_x, mac_w;
  logic [W-1:0]           b_row, mac_bias, mac_y;
  logic [AW-1:0]          w_addr;
  logic                   mac_start, mac_done, busy, layer_done, err;
  logic [NN-1:0][W-1:0]   y_out;

  logic                   model_done, stray_done;
  logic [W-1:0]           model_y, stray_y;
  assign mac_done = model_done | stray_done;
  assign mac_y    = stray_done ? stray_y : model_y;

  bit mac_enable;
  int mac_k;
  int start_cnt;
  int unstable_cnt;
  int vectors;
  int miscompares;

  logic signed [W-1:0] x_v  [NF];
  logic signed [W-1:0] wmem [NN][NF];
  logic signed [W-1:0] bmem [NN];

  mac_sequencer #(
    .NUM_FEATURES(NF), .NUM_NEURONS(NN), .FP_TOTAL_BITS(W),
    .FP_FRAC_BITS(8), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset), .layer_start(layer_start), .relu_en(relu_en),
    .x_in(x_in), .w_addr(w_addr), .w_row(w_row), .b_row(b_row),
    .mac_start(mac_start), .mac_x(mac_x), .mac_w(mac_w), .mac_bias(mac_bias),
    .mac_y(mac_y), .mac_done(mac_done), .y_out(y_out), .busy(busy),
    .layer_done(layer_done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read weight/bias memory
  always @(posedge clk) begin
    for (int f = 0; f < NF; f++) w_row[f] <= wmem[w_addr][f];
    b_row <= bmem[w_addr];
  end

  initial begin
    start_cnt = 0;
    forever begin
      @(negedge clk);
      if (mac_start === 1'b1) start_cnt++;
    end
  end

  // MAC model: answers k cycles after the sampled start pulse
  initial begin
    logic [NF-1:0][W-1:0] cap_x, cap_w;
    logic [W-1:0]         cap_b;
    longint               acc;
    model_done = 1'b0;
    model_y = '0;
    unstable_cnt = 0;
    forever begin
      @(negedge clk);
      if (mac_start === 1'b1 && mac_enable) begin
        cap_x = mac_x;
        cap_w = mac_w;
        cap_b = mac_bias;
        repeat (mac_k) @(posedge clk);
        #1;
        acc = longint'($signed(cap_b)) * 256;
        for (int f = 0; f < NF; f++)
          acc += longint'($signed(cap_x[f])) * longint'($signed(cap_w[f]));
        acc = (acc + 128) >>> 8;
        model_y = acc[W-1:0];
        if ({mac_x, mac_w, mac_bias} !== {cap_x, cap_w, cap_b}) unstable_cnt++;
        model_done = 1'b1;
        @(posedge clk);
        #1;
        model_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ref_neuron(input int n, input bit relu);
    longint acc;
    logic [W-1:0] r;
    acc = longint'(bmem[n]) * 256;
    for (int f = 0; f < NF; f++) acc += longint'(x_v[f]) * longint'(wmem[n][f]);
    acc = (acc + 128) >>> 8;
    r = acc[W-1:0];
    return (relu && r[W-1]) ? '0 : r;
  endfunction

  task automatic rand_data();
    for (int f = 0; f < NF; f++) x_v[f] = W'($urandom);
    for (int n = 0; n < NN; n++) begin
      bmem[n] = W'($urandom);
      for (int f = 0; f < NF; f++) wmem[n][f] = W'($urandom);
    end
  endtask

  task automatic run_layer(input bit relu, input int k, input int extra_at,
                           output int cycles, output bit seen);
    mac_k = k;
    for (int f = 0; f < NF; f++) x_in[f] = x_v[f];
    relu_en = relu;
    layer_start = 1'b1;
    @(posedge clk);
    #1;
    layer_start = 1'b0;
    relu_en = 1'($urandom);
    x_in = {$urandom, $urandom};
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 2000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (layer_done === 1'b1) seen = 1'b1;
      layer_start = (cycles == extra_at);
    end
    layer_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    vectors++;
    if ({busy, err, layer_done, mac_start, w_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 0", {busy, err, layer_done, mac_start, w_addr});
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({mac_x, mac_w, mac_bias, y_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h required 0", {mac_x, mac_w, mac_bias, y_out});
    end
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_directed();
    int cyc, s0, u0;
    bit seen;
    logic [NN-1:0][W-1:0] saved;
    rand_data();
    x_v[0] = 16'sd128; x_v[1] = -16'sd256; x_v[2] = 16'sd512; x_v[3] = 16'sd0;
    wmem[0][0] = 16'sd256; wmem[0][1] = 16'sd128; wmem[0][2] = -16'sd64; wmem[0][3] = -16'sd32;
    bmem[0] = 16'sd80;
    s0 = start_cnt; u0 = unstable_cnt;
    run_layer(1'b0, 3, 0, cyc, seen);
    vectors++;
    if (!seen || cyc != 29) begin
      miscompares++;
      $display("FAIL dir_latency: got seen=%0d cycles=%0d required 29", seen, cyc);
    end
    vectors++;
    if (y_out[0] !== 16'hFFD0) begin
      miscompares++;
      $display("FAIL dir_y0: got %h required ffd0", y_out[0]);
    end
    for (int i = 1; i < NN; i++) begin
      vectors++;
      if (y_out[i] !== ref_neuron(i, 1'b0)) begin
        miscompares++;
        $display("FAIL dir_y%0d: got %h required %h", i, y_out[i], ref_neuron(i, 1'b0));
      end
    end
    vectors++;
    if (start_cnt - s0 != NN || unstable_cnt != u0) begin
      miscompares++;
      $display("FAIL dir_starts: got %0d starts %0d unstable required %0d 0", start_cnt - s0, unstable_cnt - u0, NN);
    end
    saved = y_out;
    run_layer(1'b1, 3, 0, cyc, seen);
    vectors++;
    if (y_out[0] !== '0) begin
      miscompares++;
      $display("FAIL relu_y0: got %h required 0", y_out[0]);
    end
    for (int i = 1; i < NN; i++) begin
      vectors++;
      if (y_out[i] !== (saved[i][W-1] ? '0 : saved[i])) begin
        miscompares++;
        $display("FAIL relu_y%0d: got %h required %h", i, y_out[i], saved[i][W-1] ? '0 : saved[i]);
      end
    end
  endtask

  task automatic test_random_layers();
    int cyc, k, s0, u0;
    bit seen, relu;
    for (int l = 0; l < 20; l++) begin
      rand_data();
      k = $urandom_range(1, 10);
      relu = 1'($urandom);
      s0 = start_cnt; u0 = unstable_cnt;
      run_layer(relu, k, 0, cyc, seen);
      vectors++;
      if (!seen || cyc != NN * (4 + k) + 1) begin
        miscompares++;
        $display("FAIL rnd%0d_latency: got seen=%0d cycles=%0d required %0d", l, seen, cyc, NN * (4 + k) + 1);
      end
      for (int i = 0; i < NN; i++) begin
        vectors++;
        if (y_out[i] !== ref_neuron(i, relu)) begin
          miscompares++;
          $display("FAIL rnd%0d_y%0d: got %h required %h", l, i, y_out[i], ref_neuron(i, relu));
        end
      end
      vectors++;
      if (start_cnt - s0 != NN || unstable_cnt != u0) begin
        miscompares++;
        $display("FAIL rnd%0d_starts: got %0d starts %0d unstable required %0d 0", l, start_cnt - s0, unstable_cnt - u0, NN);
      end
    end
  endtask

  task automatic test_timeout();
    int cyc, s0;
    bit seen, done_seen;
    logic [NN-1:0][W-1:0] saved;
    saved = y_out;
    mac_enable = 1'b0;
    s0 = start_cnt;
    rand_data();
    for (int f = 0; f < NF; f++) x_in[f] = x_v[f];
    layer_start = 1'b1;
    @(posedge clk);
    #1 layer_start = 1'b0;
    done_seen = 1'b0;
    for (int c = 1; c <= 90; c++) begin
      @(posedge clk);
      #1;
      if (layer_done === 1'b1) done_seen = 1'b1;
      if (c == 66) begin
        vectors++;
        if (err !== 1'b0 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL to_early: got err=%b busy=%b required 0 1", err, busy);
        end
      end
      if (c == 67) begin
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL to_flag: got err=%b busy=%b required 1 0", err, busy);
        end
      end
    end
    vectors++;
    if (done_seen || start_cnt - s0 != 1 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL to_after: got done=%0d starts=%0d err=%b required 0 1 1", done_seen, start_cnt - s0, err);
    end
    vectors++;
    if (y_out !== saved) begin
      miscompares++;
      $display("FAIL to_retain: got %h required %h", y_out, saved);
    end
    mac_enable = 1'b1;
    run_layer(1'b0, 2, 0, cyc, seen);
    vectors++;
    if (!seen || cyc != NN * 6 + 1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL to_recover: got seen=%0d cycles=%0d err=%b required 1 25 0", seen, cyc, err);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, k;
    bit seen;
    mac_k = 10;
    rand_data();
    for (int f = 0; f < NF; f++) x_in[f] = x_v[f];
    layer_start = 1'b1;
    @(posedge clk);
    #1 layer_start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1 || w_addr !== 2'd2) begin
      miscompares++;
      $display("FAIL rst_pre: got busy=%b w_addr=%0d required 1 2", busy, w_addr);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({busy, err, layer_done, mac_start, w_addr, mac_x, mac_w, mac_bias, y_out} !== '0) begin
      miscompares++;
      $display("FAIL rst_async: got %h required 0", {busy, err, layer_done, mac_start, w_addr, mac_x, mac_w, mac_bias, y_out});
    end
    #1 reset = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    vectors++;
    if ({busy, err, y_out} !== '0) begin
      miscompares++;
      $display("FAIL rst_stray: got %h required 0", {busy, err, y_out});
    end
    reset = 1'b0;
    #1 reset = 1'b1;
    k = $urandom_range(1, 10);
    run_layer(1'b1, k, 0, cyc, seen);
    vectors++;
    if (!seen || cyc != NN * (4 + k) + 1) begin
      miscompares++;
      $display("FAIL rst_next_latency: got seen=%0d cycles=%0d required %0d", seen, cyc, NN * (4 + k) + 1);
    end
    for (int i = 0; i < NN; i++) begin
      vectors++;
      if (y_out[i] !== ref_neuron(i, 1'b1)) begin
        miscompares++;
        $display("FAIL rst_next_y%0d: got %h required %h", i, y_out[i], ref_neuron(i, 1'b1));
      end
    end
  endtask

  task automatic test_ignored_inputs();
    int cyc, k, s0;
    bit seen;
    logic [NN-1:0][W-1:0] saved;
    saved = y_out;
    s0 = start_cnt;
    stray_y = W'($urandom);
    stray_done = 1'b1;
    @(posedge clk);
    #1 stray_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (y_out !== saved || busy !== 1'b0 || layer_done !== 1'b0 || start_cnt != s0) begin
      miscompares++;
      $display("FAIL idle_done: got y=%h busy=%b done=%b starts=%0d required y=%h 0 0 0", y_out, busy, layer_done, start_cnt - s0, saved);
    end
    rand_data();
    k = $urandom_range(1, 10);
    s0 = start_cnt;
    run_layer(1'b0, k, 10, cyc, seen);
    vectors++;
    if (!seen || cyc != NN * (4 + k) + 1 || start_cnt - s0 != NN) begin
      miscompares++;
      $display("FAIL busy_start: got seen=%0d cycles=%0d starts=%0d required %0d %0d", seen, cyc, start_cnt - s0, NN * (4 + k) + 1, NN);
    end
    for (int i = 0; i < NN; i++) begin
      vectors++;
      if (y_out[i] !== ref_neuron(i, 1'b0)) begin
        miscompares++;
        $display("FAIL busy_y%0d: got %h required %h", i, y_out[i], ref_neuron(i, 1'b0));
      end
    end
    @(posedge clk);
    #1;
    vectors++;
    if (layer_done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse: got done=%b busy=%b required 0 0", layer_done, busy);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    layer_start = 1'b0;
    relu_en = 1'b0;
    x_in = '0;
    stray_done = 1'b0;
    stray_y = '0;
    mac_enable = 1'b1;
    mac_k = 1;
    for (int n = 0; n < NN; n++) begin
      bmem[n] = '0;
      for (int f = 0; f < NF; f++) wmem[n][f] = '0;
    end
    for (int f = 0; f < NF; f++) x_v[f] = '0;
    test_reset();
    test_directed();
    test_random_layers();
    test_timeout();
    test_reset_mid();
    test_ignored_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
